seg_scan_driver: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit 7-segment display. It is the display end of the counter/display path: it consumes packed hex nibbles from counters and drives the shared segment bus plus per-digit anode enables. Scan timing comes from an internal prescaler. Data is captured once per frame so no frame shows a mix of old and new digits. Optional leading-zero blanking and dead time between digits are included.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_scan_driver_if.sv | 33 +++
 rtl/hex7seg.sv | 20 ++
 rtl/seg_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg_scan_driver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for 7-segment decoding.
// Contents:
//   SEG_A..SEG_G  bit positions of each segment in a 7-bit pattern {g,f,e,d,c,b,a}
//   SEG_OFF       all segments dark (active-high encoding)
//   SEG_TABLE     hex digit 0..F to active-high segment pattern
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between a digit source (counters) and the scanning display driver.
// Signals:
//   iData    packed hex nibbles, nibble i is digit i
//   iDp      decimal point request per digit
//   iBlank   force a digit dark, DP included
//   iLZB     leading-zero blanking enable
//   oAn      anode enables at the pins
//   oDisplay segment bus {g,f,e,d,c,b,a} at the pins
//   oDp      decimal point segment at the pin
//   oTick    one-cycle pulse at the start of every digit slot
// Modports: master = digit source, slave = display driver.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] iData;
    logic [DIGITS-1:0]   iDp;
    logic [DIGITS-1:0]   iBlank;
    logic                iLZB;
    logic [DIGITS-1:0]   oAn;
    logic [6:0]          oDisplay;
    logic                oDp;
    logic                oTick;

    modport master (
        output iData, iDp, iBlank, iLZB,
        input  oAn, oDisplay, oDp, oTick
    );

    modport slave (
        input  iData, iDp, iBlank, iLZB,
        output oAn, oDisplay, oDp, oTick
    );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to 7-segment decoder (active-high patterns).
// Ports:
//   i_nib  4-bit hex value
//   o_seg  segment pattern {g,f,e,d,c,b,a}
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    logic [6:0] w_pat;

    assign w_pat = SEG_TABLE[i_nib];

    // Explicit reassembly pins down the {g..a} bit order at the output.
    assign o_seg = {w_pat[SEG_G], w_pat[SEG_F], w_pat[SEG_E], w_pat[SEG_D],
                    w_pat[SEG_C], w_pat[SEG_B], w_pat[SEG_A]};

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner.
// A prescaler divides CLK into digit slots of SCAN_DIV cycles; the first DEAD
// cycles of each slot keep every anode off. Display data is snapshotted once per
// frame (at the last cycle of the last digit) so a frame never mixes old and new
// digits. Outputs are registered one cycle after the (cnt, idx, shadow) state.
// Ports:
//   CLK  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seg_scan_driver_if.slave (data in, anode/segment/DP/tick out)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD           = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic rst,
    seg_scan_driver_if.slave bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIGITS-1:0] AN_PIN_OFF  = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_PIN_OFF = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_PIN_OFF  = SEG_ACTIVE_LOW;

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_sh_data;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIGITS-1:0]   r_sh_blank;
    logic                r_sh_lzb;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_tick;

    logic                w_tick;
    logic                w_last;
    logic                w_dead;
    logic [3:0]          w_nib;
    logic                w_dp_req;
    logic                w_blank_req;
    logic                w_upper_nz;
    logic                w_blanked;
    logic [DIGITS-1:0]   w_an_on;
    logic [6:0]          w_seg;

    assign w_tick = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_last = (r_idx == IW'(DIGITS - 1));
    assign w_dead = (32'(r_cnt) < 32'(DEAD));

    // Select the current digit from the shadow and find out whether any nibble
    // from the current position up to the most significant one is non-zero.
    always_comb begin
        w_nib       = 4'h0;
        w_dp_req    = 1'b0;
        w_blank_req = 1'b0;
        w_upper_nz  = 1'b0;
        w_an_on     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == r_idx) begin
                w_nib       = r_sh_data[4*i +: 4];
                w_dp_req    = r_sh_dp[i];
                w_blank_req = r_sh_blank[i];
                w_an_on[i]  = 1'b1;
            end
            if ((IW'(i) >= r_idx) && (r_sh_data[4*i +: 4] != 4'h0)) begin
                w_upper_nz = 1'b1;
            end
        end
        // Digit 0 always shows, so a value of zero still displays "0".
        w_blanked = w_blank_req || (r_sh_lzb && (r_idx != '0) && !w_upper_nz);
    end

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_sh_data  <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_sh_lzb   <= 1'b0;
            r_tick     <= 1'b0;
            r_an       <= AN_PIN_OFF;
            r_seg      <= SEG_PIN_OFF;
            r_dp       <= DP_PIN_OFF;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                r_cnt <= '0;
                if (w_last) begin
                    r_idx      <= '0;
                    r_sh_data  <= bus.iData;
                    r_sh_dp    <= bus.iDp;
                    r_sh_blank <= bus.iBlank;
                    r_sh_lzb   <= bus.iLZB;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_dead) begin
                r_an  <= AN_PIN_OFF;
                r_seg <= SEG_PIN_OFF;
                r_dp  <= DP_PIN_OFF;
            end else begin
                r_an  <= w_an_on ^ AN_PIN_OFF;
                r_seg <= (w_blanked ? SEG_OFF : w_seg) ^ {7{SEG_ACTIVE_LOW}};
                r_dp  <= (w_blanked ? 1'b0 : w_dp_req) ^ SEG_ACTIVE_LOW;
            end
        end
    end

    assign bus.oAn      = r_an;
    assign bus.oDisplay = r_seg;
    assign bus.oDp      = r_dp;
    assign bus.oTick    = r_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DG = 4;
    localparam int SD = 4;
    localparam int DT = 1;

    logic CLK;
    logic rst;

    seg_scan_driver_if #(.DIGITS(DG)) bus ();

    seg_scan_driver #(
        .DIGITS         (DG),
        .SCAN_DIV       (SD),
        .DEAD           (DT),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_pat(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Behavioural model: m_t counts clock edges since the last reset edge; the
    // slot position and digit follow from plain division of that count.
    int            m_t = 0;
    bit            m_valid = 0;
    logic [15:0]   sh_data;
    logic [3:0]    sh_dp, sh_blank;
    logic          sh_lzb;
    logic [3:0]    e_an;
    logic [6:0]    e_seg;
    logic          e_dp, e_tick;
    int            mc, md;
    bit            mbl;

    always @(posedge CLK) begin
        if (rst) begin
            m_t = 0; sh_data = '0; sh_dp = '0; sh_blank = '0; sh_lzb = 1'b0;
            e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0; e_tick = 1'b0;
            m_valid = 1;
        end else begin
            mc = m_t % SD;
            md = (m_t / SD) % DG;
            e_tick = (mc == SD - 1);
            if (mc < DT) begin
                e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
            end else begin
                e_an = ~(4'b0001 << md);
                mbl  = sh_blank[md] || (sh_lzb && md > 0 && (sh_data >> (4*md)) == 16'h0);
                e_seg = mbl ? 7'h00 : hex_pat(sh_data[4*md +: 4]);
                e_dp  = mbl ? 1'b0 : sh_dp[md];
            end
            if (m_t % (SD*DG) == SD*DG - 1) begin
                sh_data = bus.iData; sh_dp = bus.iDp; sh_blank = bus.iBlank; sh_lzb = bus.iLZB;
            end
            m_t++;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("model_an",   {28'h0, bus.oAn},      {28'h0, e_an});
            chk("model_seg",  {25'h0, bus.oDisplay}, {25'h0, e_seg});
            chk("model_dp",   {31'h0, bus.oDp},      {31'h0, e_dp});
            chk("model_tick", {31'h0, bus.oTick},    {31'h0, e_tick});
        end
    end

    task automatic wait_to(input int target);
        int g;
        g = 0;
        while (m_t != target && g < 500) begin
            @(negedge CLK);
            g++;
        end
        chk("wait_to", m_t, target);
    endtask

    task automatic run_lit(input int hold, input logic [15:0] data, input logic [3:0] dp,
                           input logic [3:0] blank, input logic lzb,
                           input logic [27:0] exp_seg, input logic [3:0] exp_dp);
        @(negedge CLK);
        bus.iData = data; bus.iDp = dp; bus.iBlank = blank; bus.iLZB = lzb;
        rst = 1'b1;
        repeat (hold) begin
            @(negedge CLK);
            chk("rst_an", {28'h0, bus.oAn}, 32'hF);
            chk("rst_tick", {31'h0, bus.oTick}, 32'h0);
        end
        rst = 1'b0;
        chk("rst_seg", {25'h0, bus.oDisplay}, 32'h0);
        chk("rst_dp", {31'h0, bus.oDp}, 32'h0);
        wait_to(2);
        chk("f1_an", {28'h0, bus.oAn}, 32'hE);
        chk("f1_seg", {25'h0, bus.oDisplay}, 32'h3F);
        wait_to(3);
        chk("tick_lo", {31'h0, bus.oTick}, 32'h0);
        wait_to(4);
        chk("tick_hi", {31'h0, bus.oTick}, 32'h1);
        wait_to(17);
        chk("dead_an", {28'h0, bus.oAn}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            wait_to(18 + 4*i);
            chk("lit_an",  {28'h0, bus.oAn},      {28'h0, ~(4'b0001 << i)});
            chk("lit_seg", {25'h0, bus.oDisplay}, {25'h0, exp_seg[7*i +: 7]});
            chk("lit_dp",  {31'h0, bus.oDp},      {31'h0, exp_dp[i]});
        end
    endtask

    logic [15:0] mask;

    initial begin
        rst = 1'b1;
        bus.iData = 16'h1234; bus.iDp = '0; bus.iBlank = '0; bus.iLZB = 1'b0;

        run_lit(3, 16'h1234, 4'b0000, 4'b0000, 1'b0,
                {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);

        // Mid-frame data change at digit 1 must not show until the next frame.
        wait_to(37);
        bus.iData = 16'hABCD;
        wait_to(42);
        chk("mid_seg2", {25'h0, bus.oDisplay}, 32'h5B);
        wait_to(46);
        chk("mid_seg3", {25'h0, bus.oDisplay}, 32'h06);
        wait_to(50);
        chk("new_seg0", {25'h0, bus.oDisplay}, 32'h5E);
        wait_to(54);
        chk("new_seg1", {25'h0, bus.oDisplay}, 32'h39);
        wait_to(58);
        chk("new_seg2", {25'h0, bus.oDisplay}, 32'h7C);
        wait_to(62);
        chk("new_seg3", {25'h0, bus.oDisplay}, 32'h77);

        // Reset in the middle of slot 2.
        wait_to(75);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        chk("mrst_an", {28'h0, bus.oAn}, 32'hF);
        chk("mrst_seg", {25'h0, bus.oDisplay}, 32'h0);
        chk("mrst_tick", {31'h0, bus.oTick}, 32'h0);
        wait_to(3);
        chk("mrst_tick3", {31'h0, bus.oTick}, 32'h0);

        run_lit(1, 16'h0040, 4'b0000, 4'b0000, 1'b1,
                {7'h00, 7'h00, 7'h66, 7'h3F}, 4'b0000);
        run_lit(1, 16'h0000, 4'b0000, 4'b0000, 1'b1,
                {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000);
        run_lit(1, 16'h5678, 4'b0101, 4'b0100, 1'b0,
                {7'h6D, 7'h00, 7'h07, 7'h7F}, 4'b0001);

        // Randomized run checked every cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    3: mask = 16'h000F;
                    default: mask = 16'h0000;
                endcase
                bus.iData  = 16'($urandom) & mask;
                bus.iDp    = 4'($urandom);
                bus.iBlank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                bus.iLZB   = 1'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge CLK);
        rst = 1'b0;
        repeat (4) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
